// File: rtl/gate_pkg.sv
// Shared types and default sizing for the parking-lot ramp arbiter.
package gate_pkg;

  localparam int unsigned CAPACITY_DEF    = 10;
  localparam int unsigned CNT_W_DEF       = 5;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2
  } gate_state_e;

  typedef enum logic {
    SIDE_IN  = 1'b0,
    SIDE_OUT = 1'b1
  } side_e;

endpackage

// File: rtl/gate_lane_arbiter_if.sv
// Sensor/actuator bundle between the gate hardware and the ramp arbiter.
interface gate_lane_if
  import gate_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             req_in;
  logic             req_out;
  logic             pass_in;
  logic             pass_out;
  logic             open_in;
  logic             open_out;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             timeout;

  modport master (
    output req_in, req_out, pass_in, pass_out,
    input  open_in, open_out, count, full, empty, timeout
  );

  modport slave (
    input  req_in, req_out, pass_in, pass_out,
    output open_in, open_out, count, full, empty, timeout
  );
endinterface

// File: rtl/gate_lane_arbiter_timer.sv
// Open-gate watchdog: counts cycles while a gate is open, flags expiry.
module gate_timer
  import gate_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk_2,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr || expire_c) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TMR_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYC-th edge after the gate opened.
  assign expire_c = en && !clr && (cnt_q == TMR_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/gate_lane_arbiter.sv
// Round-robin owner of the shared one-lane ramp; opens gates and tracks occupancy.
module gate_lane_arbiter
  import gate_pkg::*;
#(
  parameter int unsigned CAPACITY    = CAPACITY_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk_2,
  input  logic        reset_n,
  gate_lane_if.slave  bus
);
  gate_state_e      state_q, state_d;
  side_e            ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;
  logic             req_in_q, req_out_q;
  logic             full_c, empty_c, elig_in_c, elig_out_c, expire_c;

  assign full_c     = (count_q == CNT_W'(CAPACITY));
  assign empty_c    = (count_q == '0);
  // Requests are registered, so a grant lands one edge after the request is sampled.
  assign elig_in_c  = req_in_q && !full_c;
  assign elig_out_c = req_out_q && !empty_c;

  gate_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_2    (clk_2),
    .reset_n  (reset_n),
    .clr      (state_q == IDLE),
    .en       (state_q != IDLE),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= SIDE_IN;
      count_q   <= '0;
      timeout_q <= 1'b0;
      req_in_q  <= 1'b0;
      req_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      req_in_q  <= bus.req_in;
      req_out_q <= bus.req_out;
    end
  end

  // Exit priority while open: pass, then request drop, then timer expiry.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig_in_c && (!elig_out_c || ptr_q == SIDE_IN)) begin
          state_d = OPEN_IN;
          ptr_d   = SIDE_OUT;
        end else if (elig_out_c) begin
          state_d = OPEN_OUT;
          ptr_d   = SIDE_IN;
        end
      end
      OPEN_IN: begin
        if (bus.pass_in) begin
          state_d = IDLE;
          count_d = count_q + CNT_W'(1);
        end else if (!bus.req_in) begin
          state_d = IDLE;
        end else if (expire_c) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      OPEN_OUT: begin
        if (bus.pass_out) begin
          state_d = IDLE;
          count_d = count_q - CNT_W'(1);
        end else if (!bus.req_out) begin
          state_d = IDLE;
        end else if (expire_c) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.open_in  = (state_q == OPEN_IN);
    bus.open_out = (state_q == OPEN_OUT);
    bus.count    = count_q;
    bus.full     = full_c;
    bus.empty    = empty_c;
    bus.timeout  = timeout_q;
  end
endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Directed bench for gate_lane_arbiter: admit, capacity, fairness, timeout, abort, reset.
module tb_gate_lane_arbiter;
  import gate_pkg::*;

  logic clk_2   = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  logic seen;

  gate_lane_if #(.CNT_W(5)) bus ();

  gate_lane_arbiter #(.CAPACITY(10), .CNT_W(5), .TIMEOUT_CYC(16)) dut (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
    check("count_range", 32'(bus.count <= 5'd10), 32'd1);
  endtask

  task automatic admit_in();
    bus.req_in = 1'b1;
    tick();
    tick();
    bus.pass_in = 1'b1;
    bus.req_in  = 1'b0;
    tick();
    bus.pass_in = 1'b0;
  endtask

  task automatic depart_out();
    bus.req_out = 1'b1;
    tick();
    tick();
    bus.pass_out = 1'b1;
    bus.req_out  = 1'b0;
    tick();
    bus.pass_out = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_in   = 1'b0;
    bus.req_out  = 1'b0;
    bus.pass_in  = 1'b0;
    bus.pass_out = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_open_in", 32'(bus.open_in), 32'd0);
    check("rst_open_out", 32'(bus.open_out), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    reset_n = 1'b1;
    tick();

    // Entry admit with two-edge grant latency
    bus.req_in = 1'b1;
    tick();
    check("grant_wait", 32'(bus.open_in), 32'd0);
    tick();
    check("grant_open", 32'(bus.open_in), 32'd1);
    bus.pass_in = 1'b1;
    bus.req_in  = 1'b0;
    tick();
    bus.pass_in = 1'b0;
    check("admit_close", 32'(bus.open_in), 32'd0);
    check("admit_count", 32'(bus.count), 32'd1);
    check("admit_empty", 32'(bus.empty), 32'd0);

    // Capacity limit
    repeat (9) admit_in();
    check("cap_count", 32'(bus.count), 32'd10);
    check("cap_full", 32'(bus.full), 32'd1);
    bus.req_in = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | bus.open_in;
    end
    check("cap_no_grant", 32'(seen), 32'd0);
    bus.req_in = 1'b0;
    tick();
    depart_out();
    check("cap_depart_count", 32'(bus.count), 32'd9);
    check("cap_depart_full", 32'(bus.full), 32'd0);

    // Fairness with both sides contending
    repeat (4) depart_out();
    check("fair_start_count", 32'(bus.count), 32'd5);
    bus.req_in  = 1'b1;
    bus.req_out = 1'b1;
    tick();
    tick();
    check("fair_g1_in", 32'(bus.open_in), 32'd1);
    check("fair_g1_out", 32'(bus.open_out), 32'd0);
    bus.pass_in = 1'b1;
    tick();
    bus.pass_in = 1'b0;
    tick();
    check("fair_g2_out", 32'(bus.open_out), 32'd1);
    check("fair_g2_in", 32'(bus.open_in), 32'd0);
    bus.pass_out = 1'b1;
    tick();
    bus.pass_out = 1'b0;
    tick();
    check("fair_g3_in", 32'(bus.open_in), 32'd1);
    bus.pass_in = 1'b1;
    tick();
    bus.pass_in = 1'b0;
    tick();
    check("fair_g4_out", 32'(bus.open_out), 32'd1);
    bus.pass_out = 1'b1;
    bus.req_in   = 1'b0;
    bus.req_out  = 1'b0;
    tick();
    bus.pass_out = 1'b0;
    check("fair_end_count", 32'(bus.count), 32'd5);
    check("fair_end_closed", 32'(bus.open_out), 32'd0);

    // Timeout, then exit wins the next contention
    bus.req_in = 1'b1;
    tick();
    tick();
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.open_in !== 1'b1) seen = 1'b1;
      if (i == 8) bus.req_out = 1'b1;
      tick();
    end
    check("to_open_16", 32'(seen), 32'd0);
    check("to_closed", 32'(bus.open_in), 32'd0);
    check("to_pulse", 32'(bus.timeout), 32'd1);
    check("to_count", 32'(bus.count), 32'd5);
    tick();
    check("to_pulse_end", 32'(bus.timeout), 32'd0);
    check("to_next_exit", 32'(bus.open_out), 32'd1);
    check("to_next_not_in", 32'(bus.open_in), 32'd0);

    // Abort on request drop
    bus.req_out = 1'b0;
    bus.req_in  = 1'b0;
    tick();
    check("abort_closed", 32'(bus.open_out), 32'd0);
    check("abort_count", 32'(bus.count), 32'd5);
    check("abort_no_pulse", 32'(bus.timeout), 32'd0);

    // Pass on the expiry edge counts and suppresses the pulse
    bus.req_in = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("col_still_open", 32'(bus.open_in), 32'd1);
    bus.pass_in = 1'b1;
    bus.req_in  = 1'b0;
    tick();
    bus.pass_in = 1'b0;
    check("col_closed", 32'(bus.open_in), 32'd0);
    check("col_count", 32'(bus.count), 32'd6);
    check("col_no_pulse", 32'(bus.timeout), 32'd0);
    tick();
    check("col_no_pulse_late", 32'(bus.timeout), 32'd0);

    // Asynchronous reset mid-passage
    repeat (3) depart_out();
    bus.req_out = 1'b1;
    tick();
    tick();
    check("rstmid_open", 32'(bus.open_out), 32'd1);
    check("rstmid_count", 32'(bus.count), 32'd3);
    reset_n = 1'b0;
    #2;
    check("rstmid_async_close", 32'(bus.open_out), 32'd0);
    check("rstmid_async_count", 32'(bus.count), 32'd0);
    check("rstmid_async_empty", 32'(bus.empty), 32'd1);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | bus.open_out;
    end
    check("rstmid_exit_ignored", 32'(seen), 32'd0);
    check("rstmid_empty", 32'(bus.empty), 32'd1);
    bus.req_out = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gate_lane_arbiter.md
# gate_lane_arbiter

Arbiter and sequencer for the parking lot's single shared one-lane ramp, used by both the entry gate and the exit gate. Grants the lane to one requester at a time with round-robin fairness when both wait. Opens the matching gate and tracks occupancy against a capacity limit. Aborts stalled passages with a timeout. Sits between the gate sensors/switches and the gate actuators/LED display in the top-level.

## Interface
- CAPACITY, 10: maximum cars in lot.
- CNT_W, 5: width of occupancy count; must hold CAPACITY.
- TIMEOUT_CYC, 16: cycles a gate stays open waiting for pass before abort (≥2).
- clk_2  input  1  system clock, all logic on rising edge.
- reset_n  input  1  reset; asynchronous, active-low.
- req_in  input  1  level; car waiting at entry gate.
- req_out  input  1  level; car waiting at exit gate.
- pass_in  input  1  car cleared entry gate (sampled level, honored only while entry open).
- pass_out  input  1  car cleared exit gate (sampled level, honored only while exit open).
- open_in  output  1  entry gate open command.
- open_out  output  1  exit gate open command.
- count  output  CNT_W  cars currently in lot.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.
- timeout  output  1  one-cycle pulse on passage abort by timeout.

## Operation
- Reset values: open_in=0, open_out=0, count=0, full=0, empty=1, timeout=0, state IDLE, priority pointer = entry.
- States: IDLE, OPEN_IN, OPEN_OUT.
- IDLE eligibility: entry iff req_in && !full; exit iff req_out && !empty.
  - One eligible: grant it.
  - Both eligible: grant the side the priority pointer names.
  - On every grant, the pointer flips to the other side.
- OPEN_IN, exits to IDLE on the first of these conditions:
  - pass_in=1: count+1, close.
  - req_in=0 without pass_in: abort, count unchanged.
  - Timer expiry: abort, timeout pulse, count unchanged.
- OPEN_OUT behaves the same with out-side signals, and pass_out decrements count.
- pass/req of the non-granted side are ignored. No queuing of pass pulses.
- Width rule: count never wraps. Increment only from OPEN_IN (entered only when not full); decrement only from OPEN_OUT (entered only when not empty). Verification asserts 0 ≤ count ≤ CAPACITY.
- full/empty are combinational from the count register.

## Timing
- Grant latency: request seen in IDLE at edge N; open_x=1 after edge N+1 (registered output).
- Pass seen at edge M: open_x=0 and count updated after edge M (same edge), state IDLE. The next grant opens no earlier than edge M+1, so minimum gap is 1 closed cycle.
- Timeout: timer clears on grant. If no exit condition occurs, open_x drops at the TIMEOUT_CYC-th edge after opening, and timeout=1 for exactly that following cycle.
- Simultaneous events, priority pass > req drop > timeout. Pass on the expiry cycle counts and gives no timeout pulse.
- Back-to-back same side: a pass followed by a still-high req_x re-grants after 1 IDLE cycle, if the other side is not eligible and pointer-favoured.
- reset_n low mid-passage: gates close immediately (asynchronous), count=0, pointer=entry. Deassertion takes effect on the next edge.

## Structure
- Package gate_pkg holds:
  - typedef enum logic [1:0] gate_state_e {IDLE, OPEN_IN, OPEN_OUT}.
  - typedef enum logic {SIDE_IN, SIDE_OUT} side_e, used for the priority pointer.
  - Default parameter constants.
- Sub-module gate_timer: counter with clear and enable inputs, and an expire output at TIMEOUT_CYC. Same clock and reset.
- Remaining FSM, pointer and counter live in gate_lane_arbiter.

## Test plan
- Entry admit: reset, req_in=1 → open_in=1 two edges later. pass_in for 1 cycle → open_in=0, count=1, empty=0.
- Capacity: ten entry passages → count=10, full=1. Then req_in=1 for 40 cycles → open_in stays 0. req_out+pass_out → count=9.
- Fairness: count=5, req_in and req_out held high, each granted side passes. Grants alternate IN, OUT, IN, OUT; count returns to 5.
- Timeout: req_in=1 with no pass → open_in high for 16 cycles, then 0, one-cycle timeout pulse, count unchanged. The next contending grant goes to exit.
- Abort and collision: req_out drops while open_out=1 → close, count unchanged. pass_in on the expiry cycle → count+1, no timeout pulse.
- Reset mid-passage: open_out=1, count=3, reset_n low → open_out=0 and count=0 immediately. After release, empty=1 and exit requests are ignored.
